servo_pwm_multi: RTL and testbench
==================================

SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of servo channels, 1..16.
REQ-002 SHALL have parameter CMD_W, default 8: command word width.
REQ-003 SHALL have parameter FRAME_CYC, default 2_000_000: frame period in clk cycles (20 ms at 100 MHz).
REQ-004 SHALL have parameter MIN_CYC, default 100_000: pulse width for command 0.
REQ-005 SHALL have parameter MAX_CYC, default 200_000: pulse width clamp, MAX_CYC < FRAME_CYC.
REQ-006 SHALL have parameter STEP_CYC, default 392: cycles added per command LSB.
REQ-007 SHALL have parameter NEUTRAL_CYC, default 150_000: reset pulse width, MIN_CYC <= NEUTRAL_CYC <= MAX_CYC.
REQ-008 SHALL have parameter SLEW_CYC, default 0: max width change per frame; 0 means unlimited.
REQ-009 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-010 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-011 SHALL have port enable, input, 1: 0 forces all pwm low; the frame counter keeps running.
REQ-012 SHALL have port cmd_valid, input, 1: command offered.
REQ-013 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both high.
REQ-014 SHALL have port cmd_ch, input, max(1,$clog2(N_CH)): target channel.
REQ-015 SHALL have port cmd_data, input, CMD_W: position command.
REQ-016 SHALL have port cmd_err, output, 1: one-cycle pulse on an accepted command with cmd_ch >= N_CH.
REQ-017 SHALL have port pwm, output, N_CH: servo pulse outputs, registered.
REQ-018 SHALL have port frame_start, output, 1: one-cycle pulse marking the start of a frame, registered.

Function
REQ-019 Frame counter fcnt SHALL count 0..FRAME_CYC-1 and wrap to 0; width is $clog2(FRAME_CYC).
REQ-020 Accepted command SHALL set target[cmd_ch] = min(MIN_CYC + cmd_data*STEP_CYC, MAX_CYC); the product is computed at full width with no truncation before the clamp.
REQ-021 cmd_ready SHALL be 0 while fcnt == FRAME_CYC-1 (the update cycle) and 1 otherwise, outside reset.
REQ-022 Command with cmd_ch >= N_CH SHALL be accepted, dropped, and raise cmd_err the next cycle.
REQ-023 On the update cycle, each channel SHALL load width from target: if SLEW_CYC == 0 or |target-width| <= SLEW_CYC then width = target, else width moves SLEW_CYC toward target.
REQ-024 Width SHALL change only on the update cycle; a command never alters the frame in progress.
REQ-025 pwm[i] SHALL be registered as enable AND (fcnt < width[i]): high for exactly width[i] cycles per frame, with 1-cycle latency from fcnt.
REQ-026 frame_start SHALL be registered (fcnt == 0), aligned with the pwm rising edge.
REQ-027 Deasserting enable SHALL drive pwm low from the next cycle; reasserting enable SHALL resume mid-frame with the current comparison and no frame restart.
REQ-028 Multiple commands to one channel within a frame: the last accepted command SHALL win.

Reset
REQ-029 While rst is high: fcnt=0, pwm=0, frame_start=0, cmd_err=0, cmd_ready=0, all target and width = NEUTRAL_CYC.
REQ-030 First cycle after rst is released SHALL have fcnt=0; rst asserted mid-frame SHALL abort the frame and take effect on the next edge.

Structure
REQ-031 Package servo_pwm_pkg SHALL hold default parameter constants and a width-sizing function.
REQ-032 Sub-module servo_pwm_chan SHALL hold one channel's target, width, slew and compare logic, instantiated N_CH times by generate; the top holds fcnt, handshake and decode.

Verification (N_CH=4, FRAME_CYC=1000, MIN=100, MAX=200, STEP=1, NEUTRAL=150, SLEW=0 unless stated)
REQ-033 Reset released, enable=1, no commands -> every pwm high for 150 cycles in each 1000-cycle frame; frame_start every 1000 cycles.
REQ-034 cmd ch2 data 40 at fcnt=300 -> current frame pwm[2]=150 cycles, next frame 140 cycles; other channels stay at 150.
REQ-035 cmd ch0 data 255 -> pwm[0] clamped to 200 cycles from the next frame.
REQ-036 SLEW=20, cmd ch1 data 0 -> pwm[1] widths 130, 110, 100, 100 over successive frames.
REQ-037 cmd_valid held at fcnt=999 -> cmd_ready=0, accepted at fcnt=0, applied the frame after; cmd_ch=5 -> cmd_err pulse and no width change.
REQ-038 rst pulsed at fcnt=500 after ch3 is set to 180 -> pwm=0 the next cycle, then width 150 from fcnt=0.

Source files
------------

// File: rtl/servo_pwm_pkg.sv
// rtl/servo_pwm_pkg.sv - shared defaults and sizing helper for the servo PWM block
//
// Purpose: default parameter values for servo_pwm_multi and its channel
// sub-module, plus a clog2 that never returns less than one bit.
// Ports: none (package).
package servo_pwm_pkg;

  localparam int DEF_N_CH        = 2;
  localparam int DEF_CMD_W       = 8;
  localparam int DEF_FRAME_CYC   = 2_000_000;
  localparam int DEF_MIN_CYC     = 100_000;
  localparam int DEF_MAX_CYC     = 200_000;
  localparam int DEF_STEP_CYC    = 392;
  localparam int DEF_NEUTRAL_CYC = 150_000;
  localparam int DEF_SLEW_CYC    = 0;

  // Bits needed to index v items, never below 1 so single-entry ranges stay legal.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/servo_pwm_chan.sv
// rtl/servo_pwm_chan.sv - one servo channel: target, width, slew limiter, pulse compare
//
// Purpose: holds the commanded target and the width used by the running frame.
// The width only follows the target on the update cycle, optionally rate
// limited, so a command never disturbs a pulse already in progress.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   enable_i    - 0 forces the pulse low
//   update_i    - high on the last cycle of a frame
//   fcnt_i      - frame counter value
//   wr_en_i     - load wr_val_i into the target
//   wr_val_i    - clamped pulse width from the command decoder
//   pwm_o       - registered pulse output
module servo_pwm_chan
  import servo_pwm_pkg::*;
#(
  parameter int FW          = clog2_min1(DEF_FRAME_CYC),
  parameter int NEUTRAL_CYC = DEF_NEUTRAL_CYC,
  parameter int SLEW_CYC    = DEF_SLEW_CYC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_i,
  input  logic          update_i,
  input  logic [FW-1:0] fcnt_i,
  input  logic          wr_en_i,
  input  logic [FW-1:0] wr_val_i,
  output logic          pwm_o
);

  localparam logic [FW-1:0] NEUTRAL = FW'(NEUTRAL_CYC);
  localparam logic [FW-1:0] SLEW    = FW'(SLEW_CYC);

  logic [FW-1:0] target_q, target_d;
  logic [FW-1:0] width_q, width_d;
  logic [FW-1:0] mag;
  logic          pwm_q, pwm_d;

  always_comb begin
    target_d = target_q;
    if (wr_en_i) target_d = wr_val_i;
  end

  // Distance between target and current width, taken without sign so the
  // slew limit applies equally in both directions.
  always_comb begin
    mag = (target_q >= width_q) ? (target_q - width_q) : (width_q - target_q);
  end

  always_comb begin
    width_d = width_q;
    if (update_i) begin
      if (SLEW_CYC == 0 || mag <= SLEW) begin
        width_d = target_q;
      end else if (target_q > width_q) begin
        width_d = width_q + SLEW;
      end else begin
        width_d = width_q - SLEW;
      end
    end
  end

  always_comb begin
    pwm_d = enable_i && (fcnt_i < width_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q <= NEUTRAL;
      width_q  <= NEUTRAL;
      pwm_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      width_q  <= width_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo PWM generator with command port
//
// Purpose: free-running frame counter, command handshake and channel decode;
// each channel is a servo_pwm_chan instance.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   enable        - 0 forces all pwm low, frame counter keeps running
//   cmd_valid     - command offered
//   cmd_ready     - command accepted when valid and ready are both high
//   cmd_ch        - target channel
//   cmd_data      - position command
//   cmd_err       - one-cycle pulse after accepting a command to a missing channel
//   pwm           - registered servo pulses, one per channel
//   frame_start   - registered one-cycle pulse aligned with the pwm rising edge
module servo_pwm_multi
  import servo_pwm_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int CMD_W       = DEF_CMD_W,
  parameter int FRAME_CYC   = DEF_FRAME_CYC,
  parameter int MIN_CYC     = DEF_MIN_CYC,
  parameter int MAX_CYC     = DEF_MAX_CYC,
  parameter int STEP_CYC    = DEF_STEP_CYC,
  parameter int NEUTRAL_CYC = DEF_NEUTRAL_CYC,
  parameter int SLEW_CYC    = DEF_SLEW_CYC
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [clog2_min1(N_CH)-1:0] cmd_ch,
  input  logic [CMD_W-1:0]            cmd_data,
  output logic                        cmd_err,
  output logic [N_CH-1:0]             pwm,
  output logic                        frame_start
);

  localparam int CH_W = clog2_min1(N_CH);
  localparam int FW   = clog2_min1(FRAME_CYC);
  // Product width large enough that data*STEP_CYC never truncates before the clamp.
  localparam int PW   = CMD_W + 33;

  localparam logic [FW-1:0] LAST = FW'(FRAME_CYC - 1);

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          update;
  logic          accept;
  logic          ch_ok;
  logic [PW-1:0] raw_w;
  logic [FW-1:0] wr_val;
  logic          cmd_err_q, cmd_err_d;
  logic          frame_start_q, frame_start_d;

  assign update = (fcnt_q == LAST);

  always_comb begin
    fcnt_d = update ? '0 : fcnt_q + 1'b1;
  end

  // Commands are refused on the update cycle so a target write can never
  // race the width load.
  assign cmd_ready = ~rst & ~update;
  assign accept    = cmd_valid & cmd_ready;
  assign ch_ok     = (int'(cmd_ch) < N_CH);

  always_comb begin
    raw_w  = PW'(MIN_CYC) + PW'(cmd_data) * PW'(STEP_CYC);
    wr_val = (raw_w > PW'(MAX_CYC)) ? FW'(MAX_CYC) : raw_w[FW-1:0];
  end

  always_comb begin
    cmd_err_d     = accept & ~ch_ok;
    frame_start_d = (fcnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q        <= '0;
      cmd_err_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      fcnt_q        <= fcnt_d;
      cmd_err_q     <= cmd_err_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign cmd_err     = cmd_err_q;
  assign frame_start = frame_start_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    servo_pwm_chan #(
      .FW          (FW),
      .NEUTRAL_CYC (NEUTRAL_CYC),
      .SLEW_CYC    (SLEW_CYC)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .enable_i (enable),
      .update_i (update),
      .fcnt_i   (fcnt_q),
      .wr_en_i  (accept && ch_ok && (cmd_ch == CH_W'(g))),
      .wr_val_i (wr_val),
      .pwm_o    (pwm[g])
    );
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb/tb_servo_pwm_multi.sv - self-checking bench for servo_pwm_multi
module tb_servo_pwm_multi;

  localparam int F = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;

  logic       a_valid = 1'b0, a_ready, a_err, a_fs;
  logic [1:0] a_ch = '0;
  logic [7:0] a_data = '0;
  logic [3:0] a_pwm;

  logic       b_valid = 1'b0, b_ready, b_err, b_fs;
  logic [2:0] b_ch = '0;
  logic [7:0] b_data = '0;
  logic [4:0] b_pwm;

  always #5 clk = ~clk;

  servo_pwm_multi #(.N_CH(4), .CMD_W(8), .FRAME_CYC(F), .MIN_CYC(100), .MAX_CYC(200),
                    .STEP_CYC(1), .NEUTRAL_CYC(150), .SLEW_CYC(0)) u_dut_a (
    .clk(clk), .rst(rst), .enable(enable), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_ch(a_ch), .cmd_data(a_data), .cmd_err(a_err), .pwm(a_pwm), .frame_start(a_fs));

  servo_pwm_multi #(.N_CH(5), .CMD_W(8), .FRAME_CYC(F), .MIN_CYC(100), .MAX_CYC(200),
                    .STEP_CYC(1), .NEUTRAL_CYC(150), .SLEW_CYC(20)) u_dut_b (
    .clk(clk), .rst(rst), .enable(enable), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_ch(b_ch), .cmd_data(b_data), .cmd_err(b_err), .pwm(b_pwm), .frame_start(b_fs));

  typedef struct {int fc; int ch; int data;} cmd_t;
  typedef struct {int ch; int data; int exp_w;} vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int fc = 0;
  int wa[4], ta[4], wb[5], tgb[5];
  int last_a[4], last_b[5];
  cmd_t qa[$], qb[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int conv(input int d);
    int v;
    v = 100 + d * 1;
    return (v > 200) ? 200 : v;
  endfunction

  function automatic int slew_to(input int t, input int w, input int s);
    int d;
    d = t - w;
    if (s == 0 || (d <= s && d >= -s)) return t;
    return (d > 0) ? w + s : w - s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin wa[i] = 150; ta[i] = 150; end
    for (int i = 0; i < 5; i++) begin wb[i] = 150; tgb[i] = 150; end
  endtask

  // One clock: predict from the inputs present before the edge, then compare
  // the handshake outputs after it.
  task automatic tick();
    int fb, cha, chb, da, db;
    bit r, acc_a, acc_b;
    fb = fc; r = rst;
    acc_a = a_valid && !r && (fb != F - 1);
    acc_b = b_valid && !r && (fb != F - 1);
    cha = a_ch; chb = b_ch; da = a_data; db = b_data;
    @(posedge clk); #1;
    if (r) begin
      fc = 0;
      model_reset();
    end else begin
      if (acc_a && cha < 4) ta[cha] = conv(da);
      if (acc_b && chb < 5) tgb[chb] = conv(db);
      if (fb == F - 1) begin
        for (int i = 0; i < 4; i++) wa[i] = slew_to(ta[i], wa[i], 0);
        for (int i = 0; i < 5; i++) wb[i] = slew_to(tgb[i], wb[i], 20);
      end
      fc = (fb + 1) % F;
    end
    check("a_err", a_err, int'(acc_a && cha >= 4));
    check("b_err", b_err, int'(acc_b && chb >= 5));
    check("a_ready", a_ready, int'(!rst && fc != F - 1));
    check("b_ready", b_ready, int'(!rst && fc != F - 1));
  endtask

  function automatic int overlap(input int lo1, input int hi1, input int lo2, input int hi2);
    int lo, hi;
    lo = (lo1 > lo2) ? lo1 : lo2;
    hi = (hi1 < hi2) ? hi1 : hi2;
    return (hi > lo) ? hi - lo : 0;
  endfunction

  // Runs one whole frame from fcnt 0, applying queued commands and an optional
  // enable-low window [eoff_from, eoff_to), and checks each channel's high time.
  task automatic measure_frame(input int eoff_from, input int eoff_to);
    int ea[4], eb[5], ca[4], cb[5];
    int fs_a, fs_b, guard;
    guard = 0;
    while (fc != 0 && guard < F) begin tick(); guard++; end
    for (int i = 0; i < 4; i++) begin
      ea[i] = wa[i] - overlap(eoff_from, eoff_to, 0, wa[i]); ca[i] = 0;
    end
    for (int i = 0; i < 5; i++) begin
      eb[i] = wb[i] - overlap(eoff_from, eoff_to, 0, wb[i]); cb[i] = 0;
    end
    fs_a = 0; fs_b = 0;
    for (int j = 0; j < F; j++) begin
      a_valid = 1'b0; b_valid = 1'b0;
      foreach (qa[k]) if (qa[k].fc == j) begin
        a_valid = 1'b1; a_ch = 2'(qa[k].ch); a_data = 8'(qa[k].data);
      end
      foreach (qb[k]) if (qb[k].fc == j) begin
        b_valid = 1'b1; b_ch = 3'(qb[k].ch); b_data = 8'(qb[k].data);
      end
      enable = !(j >= eoff_from && j < eoff_to);
      tick();
      for (int i = 0; i < 4; i++) ca[i] += int'(a_pwm[i]);
      for (int i = 0; i < 5; i++) cb[i] += int'(b_pwm[i]);
      fs_a += int'(a_fs); fs_b += int'(b_fs);
      if (j == 0) begin
        check("a_fs_first", a_fs, 1);
        check("b_fs_first", b_fs, 1);
      end
      if (eoff_from < eoff_to && j == eoff_from) begin
        check("a_pwm_en_off", a_pwm, 0);
        check("b_pwm_en_off", b_pwm, 0);
      end
      if (eoff_from < eoff_to && j == eoff_to)
        check("a_pwm0_en_on", a_pwm[0], int'(eoff_to < wa[0]));
    end
    a_valid = 1'b0; b_valid = 1'b0; enable = 1'b1;
    qa.delete(); qb.delete();
    check("a_fs_count", fs_a, 1);
    check("b_fs_count", fs_b, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("a_width[%0d]", i), ca[i], ea[i]);
      last_a[i] = ca[i];
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("b_width[%0d]", i), cb[i], eb[i]);
      last_b[i] = cb[i];
    end
  endtask

  initial begin
    vec_t vecs[7];
    vecs[0] = '{0, 255, 200};
    vecs[1] = '{1, 0, 100};
    vecs[2] = '{3, 99, 199};
    vecs[3] = '{2, 100, 200};
    vecs[4] = '{0, 101, 200};
    vecs[5] = '{3, 50, 150};
    vecs[6] = '{1, 1, 101};

    model_reset();

    // Reset state
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_a_pwm", a_pwm, 0);
      check("rst_b_pwm", b_pwm, 0);
      check("rst_a_fs", a_fs, 0);
      check("rst_b_fs", b_fs, 0);
    end
    rst = 1'b0;

    // Idle: every channel at neutral
    measure_frame(0, 0);
    measure_frame(0, 0);
    check("idle_a0", last_a[0], 150);
    check("idle_b4", last_b[4], 150);

    // Mid-frame command leaves the running frame alone; slew on B
    qa.push_back('{300, 2, 40});
    qb.push_back('{300, 1, 0});
    measure_frame(0, 0);
    check("a2_cur_frame", last_a[2], 150);
    check("b1_cur_frame", last_b[1], 150);
    measure_frame(0, 0);
    check("a2_next_frame", last_a[2], 140);
    check("a0_untouched", last_a[0], 150);
    check("b1_slew_1", last_b[1], 130);
    measure_frame(0, 0);
    check("b1_slew_2", last_b[1], 110);
    measure_frame(0, 0);
    check("b1_slew_3", last_b[1], 100);
    measure_frame(0, 0);
    check("b1_slew_4", last_b[1], 100);

    // Conversion / clamp table, each result seen in the following frame
    for (int k = 0; k < 7; k++) begin
      qa.push_back('{200 + k * 37, vecs[k].ch, vecs[k].data});
      measure_frame(0, 0);
      if (k > 0) check($sformatf("vec%0d", k - 1), last_a[vecs[k - 1].ch], vecs[k - 1].exp_w);
    end
    measure_frame(0, 0);
    check("vec6", last_a[vecs[6].ch], vecs[6].exp_w);

    // Last command in a frame wins
    qa.push_back('{100, 1, 10});
    qa.push_back('{400, 1, 70});
    measure_frame(0, 0);
    measure_frame(0, 0);
    check("last_wins", last_a[1], 170);

    // Command held across the update cycle; out-of-range channel on B
    while (fc != F - 1) tick();
    a_valid = 1'b1; a_ch = 2'd0; a_data = 8'd60;
    b_valid = 1'b1; b_ch = 3'd5; b_data = 8'd77;
    #1;
    check("ready_low_at_999", a_ready, 0);
    tick();
    qa.push_back('{0, 0, 60});
    qb.push_back('{0, 5, 77});
    measure_frame(0, 0);
    check("held_cur_frame", last_a[0], 200);
    measure_frame(0, 0);
    check("held_applied", last_a[0], 160);

    // Enable dropped mid-frame and restored
    measure_frame(50, 100);
    measure_frame(120, 400);

    // Mid-frame reset after ch3 set to 180
    qa.push_back('{10, 3, 80});
    measure_frame(0, 0);
    measure_frame(0, 0);
    check("a3_180", last_a[3], 180);
    while (fc != 500) tick();
    rst = 1'b1;
    tick();
    check("midrst_a_pwm", a_pwm, 0);
    check("midrst_b_pwm", b_pwm, 0);
    rst = 1'b0;
    measure_frame(0, 0);
    check("after_rst_a3", last_a[3], 150);

    // Random commands against the model
    for (int f = 0; f < 6; f++) begin
      int na, nb;
      na = $urandom_range(0, 3);
      nb = $urandom_range(0, 3);
      for (int k = 0; k < na; k++)
        qa.push_back('{$urandom_range(0, F - 1), $urandom_range(0, 3), $urandom_range(0, 255)});
      for (int k = 0; k < nb; k++)
        qb.push_back('{$urandom_range(0, F - 1), $urandom_range(0, 6), $urandom_range(0, 255)});
      measure_frame(0, 0);
    end
    measure_frame(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
